uart_msg_tx: RTL and testbench
==============================

# uart_msg_tx

Alarm-event message formatter feeding the serial transmitter. Queues alarm events (event type + zone) in a small FIFO, expands each into a fixed 8-byte ASCII line such as "ALM Z3\r\n", and hands the bytes one at a time to the 8N1 UART transmitter through its start/busy handshake. Sits between the alarm controller FSM and the UART transmitter.

## Interface

Parameters:
- FIFO_DEPTH, 4, number of queued events; power of 2, 2..16.

Ports:
- i_clk  input  1  system clock (100 MHz)
- i_rst_n  input  1  synchronous active-low reset
- i_event_valid  input  1  one-cycle strobe: event present on i_event_code/i_zone
- i_event_code  input  2  0=ARM, 1=DIS, 2=ALM, 3=CLR
- i_zone  input  4  zone number 0..15
- i_tx_busy  input  1  transmitter busy flag
- o_tx_start  output  1  one-cycle byte-start pulse to the transmitter
- o_tx_data  output  8  byte to transmit; valid while o_tx_start=1
- o_busy  output  1  1 while FIFO non-empty or a message is in progress
- o_fifo_count  output  $clog2(FIFO_DEPTH)+1  queued events (excludes the message in progress)
- o_drop  output  1  one-cycle pulse: event discarded because FIFO full
- o_drop_cnt  output  8  saturating count of dropped events

## Operation

- Reset (i_rst_n=0 at a clock edge): all outputs 0, FIFO emptied, FSM to IDLE, byte index 0, drop counter 0. Reset mid-message abandons the message; no further o_tx_start.
- FIFO entry = {code, zone}, 6 bits. Push when i_event_valid=1 and (not full, or a pop occurs in the same cycle). Push while full without a pop: event discarded, o_drop=1 for that cycle, o_drop_cnt increments, saturating at 255.
- Message bytes, index 0..7: tag[0], tag[1], tag[2], 0x20, 0x5A ('Z'), hex digit, 0x0D, 0x0A.
- Tags: ARM="ARM" (41 52 4D), DIS="DIS" (44 49 53), ALM="ALM" (41 4C 4D), CLR="CLR" (43 4C 52).
- Hex digit: zone 0..9 maps to 0x30+zone; zone 10..15 maps to 0x41+(zone-10), uppercase.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the message register, index=0, go to SEND.
  - SEND: if i_tx_busy=0, assert o_tx_start for one cycle with o_tx_data=byte[index], go to WAIT_HI; otherwise stay.
  - WAIT_HI: wait for i_tx_busy=1, then go to WAIT_LO.
  - WAIT_LO: wait for i_tx_busy=0. If index=7, go to IDLE; otherwise index+1 and go to SEND.
- Exactly one o_tx_start per byte. Bytes are never skipped or repeated. Messages go out in FIFO order.
- o_busy = (state != IDLE) or (count != 0).

## Timing

- All outputs are registered.
- Event accepted at edge k with the FSM in IDLE and the FIFO empty:
  - pop at edge k+1;
  - o_tx_start=1 in the cycle following edge k+2, carrying byte 0.
- The transmitter raises busy on the cycle after it sees start. WAIT_HI therefore tolerates a gap of 1 or more cycles.
- Inter-byte: i_tx_busy is sampled low in WAIT_LO at edge m. The next o_tx_start is asserted after edge m+1, i.e. 2 cycles after busy falls.
- Back-to-back messages: after byte 7's busy falls, the next message's byte 0 starts 3 cycles later (IDLE adds one cycle).
- A push and a pop in the same cycle leave o_fifo_count unchanged. This is allowed at full.
- o_fifo_count updates the cycle after the push or pop.

## Test plan

- Reset: hold i_rst_n=0 for 3 cycles with i_event_valid=1 -> all outputs 0, no push, o_fifo_count=0.
- Single event, code=2, zone=3, with a behavioural busy model (busy rises 1 cycle after start, lasts 20 cycles) -> bytes 41 4C 4D 20 5A 33 0D 0A, exactly 8 start pulses, o_busy returns to 0.
- Zone mapping: zones 9, 10 and 15 with code=0 -> hex digits 0x39, 0x41 and 0x46 respectively.
- Overflow: 7 back-to-back events with FIFO_DEPTH=4 -> 5 messages sent in order, 2 o_drop pulses, o_drop_cnt=2, peak o_fifo_count=4.
- Busy stall: hold i_tx_busy=1 for 100 cycles before byte 0 -> no o_tx_start during the hold; byte 0 issued 1 cycle after busy falls.
- Reset mid-message: assert i_rst_n=0 during byte 4 -> o_tx_start stays 0 and the FIFO is empty. A subsequent event produces a complete fresh message starting at byte 0.

Source files
------------

// File: rtl/uart_msg_tx.sv
// Alarm-event message formatter: queues {code, zone} events and streams each one
// as an 8-byte ASCII line ("ALM Z3\r\n") to an 8N1 transmitter via start/busy.
module uart_msg_tx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_event_valid,
    input  logic [1:0]                    i_event_code,
    input  logic [3:0]                    i_zone,
    input  logic                          i_tx_busy,
    output logic                          o_tx_start,
    output logic [7:0]                    o_tx_data,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
    output logic                          o_drop,
    output logic [7:0]                    o_drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [5:0]      msg_q, msg_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            busy_q, busy_d;
    logic            drop_q, drop_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic [5:0]      fifo_mem_q [FIFO_DEPTH];

    logic            full;
    logic            push;
    logic            pop;
    logic            drop;

    // Byte idx of the message line for entry {code, zone}.
    function automatic logic [7:0] msg_byte(input logic [5:0] ent, input logic [2:0] idx);
        logic [23:0] tag;
        logic [3:0]  zone;
        logic [7:0]  hex;
        zone = ent[3:0];
        case (ent[5:4])
            2'd0:    tag = 24'h41524D;
            2'd1:    tag = 24'h444953;
            2'd2:    tag = 24'h414C4D;
            default: tag = 24'h434C52;
        endcase
        // 0x37 + zone lands on 'A' for zone 10
        hex = (zone < 4'd10) ? (8'h30 + {4'h0, zone}) : (8'h37 + {4'h0, zone});
        case (idx)
            3'd0:    msg_byte = tag[23:16];
            3'd1:    msg_byte = tag[15:8];
            3'd2:    msg_byte = tag[7:0];
            3'd3:    msg_byte = 8'h20;
            3'd4:    msg_byte = 8'h5A;
            3'd5:    msg_byte = hex;
            3'd6:    msg_byte = 8'h0D;
            default: msg_byte = 8'h0A;
        endcase
    endfunction

    // Message FSM: pop in IDLE, one start per byte, follow busy high then low.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        msg_d      = msg_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        pop        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    msg_d   = fifo_mem_q[rd_ptr_q];
                    idx_d   = 3'd0;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (!i_tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = msg_byte(msg_q, idx_q);
                    state_d    = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                if (i_tx_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!i_tx_busy) begin
                    if (idx_q == 3'd7) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO bookkeeping; a simultaneous pop frees the slot a push needs when full.
    always_comb begin
        full       = (count_q == CW'(FIFO_DEPTH));
        push       = i_event_valid && (!full || pop);
        drop       = i_event_valid && !push;
        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        drop_d     = drop;
        drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;
        busy_d     = (state_d != ST_IDLE) || (count_d != '0);
    end

    // Storage needs no reset: the pointers and count define what is valid.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo
            always_ff @(posedge i_clk) begin
                if (i_rst_n && push && wr_ptr_q == AW'(gi)) begin
                    fifo_mem_q[gi] <= {i_event_code, i_zone};
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= 3'd0;
            msg_q      <= 6'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'd0;
            busy_q     <= 1'b0;
            drop_q     <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            msg_q      <= msg_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            busy_q     <= busy_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign o_tx_start   = tx_start_q;
    assign o_tx_data    = tx_data_q;
    assign o_busy       = busy_q;
    assign o_fifo_count = count_q;
    assign o_drop       = drop_q;
    assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// Scoreboard bench for uart_msg_tx: expected bytes are queued per accepted event
// and popped by a monitor on every o_tx_start, alongside latency and overflow checks.
module tb_uart_msg_tx;

    localparam int DEPTH    = 4;
    localparam int BUSY_LEN = 20;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ev_valid = 1'b0;
    logic [1:0]    ev_code = 2'd0;
    logic [3:0]    ev_zone = 4'd0;
    logic          model_busy = 1'b0;
    logic          stall_busy = 1'b0;
    logic          tx_busy;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          drop;
    logic [7:0]    drop_cnt;

    int            checks = 0;
    int            errors = 0;
    int            starts = 0;
    int            drops  = 0;
    int            peak   = 0;
    logic          prev_start = 1'b0;
    logic [7:0]    exp_q [$];
    string         tags [4];
    string         hexs;

    assign tx_busy = model_busy | stall_busy;

    always #5 clk = ~clk;

    uart_msg_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_event_valid(ev_valid),
        .i_event_code (ev_code),
        .i_zone       (ev_zone),
        .i_tx_busy    (tx_busy),
        .o_tx_start   (tx_start),
        .o_tx_data    (tx_data),
        .o_busy       (busy),
        .o_fifo_count (fifo_count),
        .o_drop       (drop),
        .o_drop_cnt   (drop_cnt)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference line: three-letter tag, space, 'Z', hex zone digit, CR, LF.
    task automatic push_event(input logic [1:0] code, input logic [3:0] zone);
        string t;
        t = tags[code];
        exp_q.push_back(t[0]);
        exp_q.push_back(t[1]);
        exp_q.push_back(t[2]);
        exp_q.push_back(8'h20);
        exp_q.push_back(8'h5A);
        exp_q.push_back(hexs[int'(zone)]);
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        $display("event code=%0d zone=%0d queued (%0d bytes pending)", code, zone, exp_q.size());
    endtask

    // Called #1 after an edge; the strobe is sampled at the following edge.
    task automatic issue(input logic [1:0] code, input logic [3:0] zone);
        ev_valid = 1'b1;
        ev_code  = code;
        ev_zone  = zone;
        push_event(code, zone);
        @(posedge clk); #1;
        ev_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && busy == 1'b0 && model_busy == 1'b0) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, (exp_q.size() == 0 && busy == 1'b0) ? 1 : 0, 1);
    endtask

    // Transmitter model: busy rises the cycle after start is seen, lasts BUSY_LEN cycles.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (tx_start === 1'b1) begin
                @(posedge clk); #1;
                model_busy = 1'b1;
                repeat (BUSY_LEN) @(posedge clk);
                #1;
                model_busy = 1'b0;
            end
        end
    end

    // Monitor: every start pulse must carry the next expected byte.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            starts++;
            if (prev_start) check("start_width", 2, 1);
            if (exp_q.size() == 0) begin
                check("unexpected_start", int'(tx_data), 256);
            end else begin
                automatic logic [7:0] e = exp_q.pop_front();
                check("tx_byte", int'(tx_data), int'(e));
                $display("byte %02h expected %02h", tx_data, e);
            end
        end
        prev_start = (tx_start === 1'b1);
        if (drop === 1'b1) drops++;
        if (int'(fifo_count) > peak && !$isunknown(fifo_count)) peak = int'(fifo_count);
    end

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int n;
        tags[0] = "ARM";
        tags[1] = "DIS";
        tags[2] = "ALM";
        tags[3] = "CLR";
        hexs    = "0123456789ABCDEF";

        // Reset held with a strobe present: nothing may be queued.
        rst_n    = 1'b0;
        ev_valid = 1'b1;
        ev_code  = 2'd2;
        ev_zone  = 4'd5;
        repeat (3) begin
            @(posedge clk); #1;
            check("rst_tx_start", int'(tx_start), 0);
            check("rst_fifo_count", int'(fifo_count), 0);
        end
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_drop", int'(drop), 0);
        check("rst_drop_cnt", int'(drop_cnt), 0);
        rst_n    = 1'b1;
        ev_valid = 1'b0;
        @(posedge clk); #1;
        check("post_rst_count", int'(fifo_count), 0);

        // Single ALM Z3 with first-byte latency.
        s0 = starts;
        ev_valid = 1'b1;
        ev_code  = 2'd2;
        ev_zone  = 4'd3;
        push_event(2'd2, 4'd3);
        @(posedge clk); #1;
        ev_valid = 1'b0;
        check("lat_count_after_push", int'(fifo_count), 1);
        check("lat_busy_after_push", int'(busy), 1);
        @(posedge clk); #1;
        check("lat_no_start_at_pop", int'(tx_start), 0);
        check("lat_count_after_pop", int'(fifo_count), 0);
        @(posedge clk); #1;
        check("lat_start_byte0", int'(tx_start), 1);
        check("lat_data_byte0", int'(tx_data), 8'h41);
        wait_idle("single_idle", 2000);
        check("single_start_count", starts - s0, 8);

        // Zone digit boundaries.
        s0 = starts;
        issue(2'd0, 4'd9);
        repeat (3) @(posedge clk);
        #1;
        issue(2'd0, 4'd10);
        repeat (5) @(posedge clk);
        #1;
        issue(2'd0, 4'd15);
        wait_idle("zone_idle", 6000);
        check("zone_start_count", starts - s0, 24);

        // Random events, paced so the queue can never be full.
        s0 = starts;
        drops = 0;
        for (int i = 0; i < 12; i++) begin
            repeat ($urandom_range(1, 80)) @(posedge clk);
            #1;
            n = 0;
            while ((exp_q.size() + 7) / 8 >= DEPTH && n < 5000) begin
                @(posedge clk); #1;
                n++;
            end
            issue(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        wait_idle("rand_idle", 20000);
        check("rand_start_count", starts - s0, 96);
        check("rand_drops", drops, 0);
        check("rand_drop_cnt", int'(drop_cnt), 0);

        // Overflow: 7 consecutive strobes from idle; one goes straight to the
        // message register, DEPTH fill the FIFO, the rest are dropped.
        s0 = starts;
        drops = 0;
        peak = 0;
        for (int i = 0; i < 7; i++) begin
            ev_valid = 1'b1;
            ev_code  = 2'($urandom_range(0, 3));
            ev_zone  = 4'($urandom_range(0, 15));
            if (i < DEPTH + 1) push_event(ev_code, ev_zone);
            @(posedge clk); #1;
        end
        ev_valid = 1'b0;
        wait_idle("ovf_idle", 12000);
        check("ovf_start_count", starts - s0, 40);
        check("ovf_drop_pulses", drops, 2);
        check("ovf_drop_cnt", int'(drop_cnt), 2);
        check("ovf_peak_count", peak, DEPTH);

        // Transmitter held busy before byte 0.
        stall_busy = 1'b1;
        s0 = starts;
        issue(2'd3, 4'd12);
        repeat (100) @(posedge clk);
        #1;
        check("stall_no_start", starts - s0, 0);
        stall_busy = 1'b0;
        @(posedge clk); #1;
        check("stall_release_start", int'(tx_start), 1);
        wait_idle("stall_idle", 2000);
        check("stall_start_count", starts - s0, 8);

        // Reset while byte 4 of a message is in flight, with a second queued.
        s0 = starts;
        issue(2'd1, 4'd7);
        repeat (4) @(posedge clk);
        #1;
        issue(2'd2, 4'd1);
        n = 0;
        while (starts - s0 < 5 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_reached_byte4", starts - s0, 5);
        rst_n = 1'b0;
        exp_q.delete();
        s0 = starts;
        repeat (3) begin
            @(posedge clk); #1;
            check("midrst_tx_start", int'(tx_start), 0);
        end
        check("midrst_fifo_count", int'(fifo_count), 0);
        check("midrst_busy", int'(busy), 0);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check("midrst_no_more_starts", starts - s0, 0);
        s0 = starts;
        issue(2'd0, 4'd11);
        wait_idle("midrst_fresh_idle", 2000);
        check("midrst_fresh_count", starts - s0, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
